// File: rtl/div_pkg.sv
// Shared definitions for the iterative 32-bit divider: widths, step count,
// FSM state encoding, the divide-by-zero quotient and a two's-complement helper.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_STEPS = 32;

  localparam logic [31:0] DZ_QUOTIENT = 32'hFFFF_FFFF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DZ   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Two's-complement negation (~x + 1); 32'h8000_0000 maps to itself.
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/cla_adder32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups with a second-level
// group carry chain. Used by the divider as its per-step subtractor (A + ~B + 1).
module cla_adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [7:0]  grp_g;
  logic [7:0]  grp_p;
  logic [7:0]  grp_cin;
  logic        carry_out;

  assign g = a & b;
  assign p = a ^ b;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_grp
      localparam int B = gi * 4;

      // Group generate/propagate for the second-level lookahead.
      assign grp_g[gi] = g[B+3]
                       | (p[B+3] & g[B+2])
                       | (p[B+3] & p[B+2] & g[B+1])
                       | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign grp_p[gi] = p[B+3] & p[B+2] & p[B+1] & p[B];

      // Per-bit carries inside the group, all derived from the group carry-in.
      assign c[B]   = grp_cin[gi];
      assign c[B+1] = g[B] | (p[B] & grp_cin[gi]);
      assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & grp_cin[gi]);
      assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                    | (p[B+2] & p[B+1] & p[B] & grp_cin[gi]);
    end
  endgenerate

  // Second-level carry chain across the eight groups; a local variable keeps
  // the chain out of the group-carry vector itself.
  always_comb begin
    logic carry;
    carry   = cin;
    grp_cin = '0;
    for (int i = 0; i < 8; i++) begin
      grp_cin[i] = carry;
      carry      = grp_g[i] | (grp_p[i] & carry);
    end
    carry_out = carry;
  end

  assign sum  = p ^ c;
  assign cout = carry_out;

endmodule

// File: rtl/div32_iter.sv
// Multi-cycle 32-bit restoring divider, one quotient bit per clock, with a
// start/busy/done handshake. Build option: define DIV_SIGNED_EN to honour
// is_signed (magnitude division with sign fixup on the edge entering DONE);
// otherwise every operation is unsigned and is_signed is ignored.
module div32_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      prem_reg;      // partial remainder
  logic [31:0]      acc_reg;       // dividend bits shifting out, quotient bits shifting in
  logic [31:0]      dsr_reg;       // divisor magnitude
  logic [31:0]      orig_dvd_reg;  // dividend as presented, for divide-by-zero
  logic             neg_q_reg;
  logic             neg_r_reg;

  logic        op_signed;
  logic [31:0] dvd_mag;
  logic [31:0] dsr_mag;
  logic [31:0] shifted;
  logic [31:0] diff;
  logic        cout;
  logic        take;
  logic [31:0] rem_step;
  logic [31:0] acc_step;
  logic [31:0] q_final;
  logic [31:0] r_final;

`ifdef DIV_SIGNED_EN
  assign op_signed = is_signed;
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign op_signed        = 1'b0;
`endif

  // Operand magnitudes are taken at accept; for unsigned ops they pass through.
  assign dvd_mag = (op_signed && dividend[31]) ? neg32(dividend) : dividend;
  assign dsr_mag = (op_signed && divisor[31])  ? neg32(divisor)  : divisor;

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  assign shifted = {prem_reg[30:0], acc_reg[31]};

  cla_adder32 u_sub (
    .a    (shifted),
    .b    (~dsr_reg),
    .cin  (1'b1),
    .sum  (diff),
    .cout (cout)
  );

  // A bit shifted out of the top means the true value exceeds 32 bits and is
  // therefore at least the divisor, even when the 32-bit subtract borrows.
  assign take     = prem_reg[31] | cout;
  assign rem_step = take ? diff : shifted;
  assign acc_step = {acc_reg[30:0], take};

  assign q_final = neg_q_reg ? neg32(acc_step) : acc_step;
  assign r_final = neg_r_reg ? neg32(rem_step) : rem_step;

  // Control FSM, datapath registers and held result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      prem_reg     <= '0;
      acc_reg      <= '0;
      dsr_reg      <= '0;
      orig_dvd_reg <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      div_zero     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            prem_reg     <= '0;
            acc_reg      <= dvd_mag;
            dsr_reg      <= dsr_mag;
            orig_dvd_reg <= dividend;
            neg_q_reg    <= op_signed & (dividend[31] ^ divisor[31]);
            neg_r_reg    <= op_signed & dividend[31];
            cnt_reg      <= '0;
            busy         <= 1'b1;
            div_zero     <= 1'b0;
            state_reg    <= (divisor == 32'd0) ? ST_DZ : ST_RUN;
          end
        end
        ST_RUN: begin
          prem_reg <= rem_step;
          acc_reg  <= acc_step;
          cnt_reg  <= cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_STEP) begin
            quotient  <= q_final;
            remainder <= r_final;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        ST_DZ: begin
          quotient  <= DZ_QUOTIENT;
          remainder <= orig_dvd_reg;
          div_zero  <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b1;
          state_reg <= ST_DONE;
        end
        ST_DONE: begin
          done      <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div32_iter.sv
// Self-checking bench for div32_iter: scoreboard queue of expected results,
// pushed at launch and popped on the done pulse.
module tb_div32_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  div32_iter dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  // Reference results from the language's own division operators.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t   e;
    longint sa;
    longint sb_l;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.lat = 2;
    end else if (s) begin
      sa   = longint'($signed(a));
      sb_l = longint'($signed(b));
      e.q = 32'(sa / sb_l); e.r = 32'(sa % sb_l); e.dz = 1'b0; e.lat = 33;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0; e.lat = 33;
    end
    return e;
  endfunction

  // Wait for idle, present one start for one edge, push the expected result.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    int w;
    w = 0;
    @(negedge clk);
    while ((busy || done) && w < 100) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (w >= 100) begin
      n_bad++;
      $display("FAIL idle_wait: busy=%0b done=%0b, required idle", busy, done);
    end
    dividend = a; divisor = b; is_signed = s; start = 1'b1;
    sb.push_back(model(a, b, s & SIGNED_EN));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Launch and follow one operation to its done pulse, checking everything.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    int   lat;
    exp_t e;
    logic [31:0] q_seen;
    launch(a, b, s);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_cmp++;
        if (busy !== 1'b1 || div_zero !== 1'b0) begin
          n_bad++;
          $display("FAIL accept_state: busy=%0b div_zero=%0b, required busy=1 div_zero=0", busy, div_zero);
        end
      end
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    e = sb.pop_front();
    $display("op %h / %h s=%0b -> q=%h r=%h dz=%0b lat=%0d", a, b, s, quotient, remainder, div_zero, lat);
    n_cmp++;
    if (lat != e.lat) begin
      n_bad++;
      $display("FAIL latency: got %0d cycles, required %0d", lat, e.lat);
    end
    n_cmp++;
    if (quotient !== e.q) begin
      n_bad++;
      $display("FAIL quotient: got %h, required %h", quotient, e.q);
    end
    n_cmp++;
    if (remainder !== e.r) begin
      n_bad++;
      $display("FAIL remainder: got %h, required %h", remainder, e.r);
    end
    n_cmp++;
    if (div_zero !== e.dz || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL done_flags: div_zero=%0b busy=%0b, required div_zero=%0b busy=0", div_zero, busy, e.dz);
    end
    q_seen = quotient;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || quotient !== q_seen) begin
      n_bad++;
      $display("FAIL done_pulse_hold: done=%0b q=%h, required done=0 q=%h", done, quotient, q_seen);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0 || div_zero !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_values: busy=%0b done=%0b q=%h r=%h dz=%0b, required all 0",
               busy, done, quotient, remainder, div_zero);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_idle: busy=%0b done=%0b, required 0 0", busy, done);
    end
  endtask

  task automatic test_unsigned();
    run_op(32'd100, 32'd7, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(32'd3, 32'd10, 1'b0);
    run_op(32'hDEAD_BEEF, 32'h8000_0001, 1'b0);
  endtask

  task automatic test_div_zero();
    run_op(32'd5, 32'd0, 1'b0);
    run_op(32'd100, 32'd7, 1'b0);   // div_zero must clear on the next accept
  endtask

  task automatic test_ignore_start();
    int          dones;
    int          lat;
    logic [31:0] q_at;
    logic [31:0] r_at;
    exp_t        e;
    dones = 0; lat = 0; q_at = '0; r_at = '0;
    launch(32'd1000, 32'd3, 1'b0);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 10) begin
        dividend = 32'd77; divisor = 32'd0; start = 1'b1;
      end else if (k == 11) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        dones++;
        if (dones == 1) begin
          lat = k; q_at = quotient; r_at = remainder;
        end
      end
    end
    e = sb.pop_front();
    $display("op 000003e8 / 00000003 with stray start -> q=%h r=%h dones=%0d lat=%0d", q_at, r_at, dones, lat);
    n_cmp++;
    if (dones != 1) begin
      n_bad++;
      $display("FAIL ignore_start_pulses: got %0d done pulses, required 1", dones);
    end
    n_cmp++;
    if (q_at !== e.q || r_at !== e.r || lat != e.lat) begin
      n_bad++;
      $display("FAIL ignore_start_result: q=%h r=%h lat=%0d, required q=%h r=%h lat=%0d",
               q_at, r_at, lat, e.q, e.r, e.lat);
    end
    n_cmp++;
    if (quotient !== e.q || div_zero !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore_start_hold: q=%h dz=%0b, required q=%h dz=0", quotient, div_zero, e.q);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    launch(32'd123456789, 32'd1000, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0 || div_zero !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_values: busy=%0b done=%0b q=%h r=%h dz=%0b, required all 0",
               busy, done, quotient, remainder, div_zero);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    $display("op 075bcd15 / 000003e8 aborted by reset, activity cycles after=%0d", dones);
    n_cmp++;
    if (dones != 0) begin
      n_bad++;
      $display("FAIL reset_mid_quiet: got %0d busy/done cycles, required 0", dones);
    end
    run_op(32'd77, 32'd5, 1'b0);
  endtask

  task automatic test_signed();
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1);            // -7 / 2
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);    // most negative / -1
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1);            // 7 / -2
    run_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1);    // -7 / -2
    run_op(32'hFFFF_FFF9, 32'd0, 1'b1);            // -7 / 0
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (b == 32'd0) b = 32'd3;
      run_op(a, b, 1'(i % 3 == 0));
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_div_zero();
    test_ignore_start();
    test_signed();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
